// File: rtl/mouse_pkg.sv
// Shared types for the mouse click decoder: click type encoding, FSM states,
// cell index width and the captured click request.
package mouse_pkg;

    localparam int CELL_IDX_W = 5;
    localparam int POS_W      = 12;

    typedef enum logic [1:0] {
        CLICK_NONE  = 2'b00,
        CLICK_LEFT  = 2'b01,
        CLICK_RIGHT = 2'b10,
        CLICK_CHORD = 2'b11
    } click_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RANGE = 3'd1,
        ST_COL   = 3'd2,
        ST_ROW   = 3'd3,
        ST_VALID = 3'd4
    } state_e;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        click_type_e      ctype;
    } click_req_t;

endpackage

// File: rtl/button_edge_det.sv
// Rising-edge press detector for one mouse button level.
module button_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press
);

    logic btn_q, btn_d;

    always_comb btn_d = btn_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_q <= 1'b0;
        else        btn_q <= btn_d;
    end

    assign press = btn_in & ~btn_q;

endmodule

// File: rtl/mouse_click_decoder.sv
// Converts mouse button presses into board cell events via repeated-subtraction
// division. Define CLICK_STATS_EN to add the saturating drop_cnt output.
module mouse_click_decoder
    import mouse_pkg::*;
#(
    parameter int BOARD_XPOS = 240,
    parameter int BOARD_YPOS = 100,
    parameter int CELL_SIZE  = 40,
    parameter int GRID_SIZE  = 16
) (
`ifdef CLICK_STATS_EN
    output logic [7:0]            drop_cnt,
`endif
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [POS_W-1:0]      xpos_in,
    input  logic [POS_W-1:0]      ypos_in,
    input  logic                  left_in,
    input  logic                  right_in,
    output logic                  click_valid,
    input  logic                  click_ready,
    output logic [CELL_IDX_W-1:0] click_col,
    output logic [CELL_IDX_W-1:0] click_row,
    output logic [1:0]            click_type,
    output logic                  busy
);

    localparam logic [12:0] X_LO = 13'(BOARD_XPOS);
    localparam logic [12:0] X_HI = 13'(BOARD_XPOS + GRID_SIZE * CELL_SIZE);
    localparam logic [12:0] Y_LO = 13'(BOARD_YPOS);
    localparam logic [12:0] Y_HI = 13'(BOARD_YPOS + GRID_SIZE * CELL_SIZE);
    localparam logic [POS_W-1:0] X_OFS = POS_W'(BOARD_XPOS);
    localparam logic [POS_W-1:0] Y_OFS = POS_W'(BOARD_YPOS);
    localparam logic [POS_W-1:0] CELL  = POS_W'(CELL_SIZE);

    // Bit 0 is the left button, bit 1 the right, matching the click_type encoding.
    logic [1:0] btn_in, press;
    assign btn_in = {right_in, left_in};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        button_edge_det u_det (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_in (btn_in[b]),
            .press  (press[b])
        );
    end

    state_e                state_q, state_d;
    click_req_t            req_q, req_d;
    logic [POS_W-1:0]      rem_q, rem_d;
    logic [CELL_IDX_W-1:0] col_q, col_d;
    logic [CELL_IDX_W-1:0] row_q, row_d;
    logic                  outside;

    always_comb begin
        outside = ({1'b0, req_q.x} < X_LO) || ({1'b0, req_q.x} >= X_HI) ||
                  ({1'b0, req_q.y} < Y_LO) || ({1'b0, req_q.y} >= Y_HI);
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rem_d   = rem_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (|press) begin
                    req_d.x     = xpos_in;
                    req_d.y     = ypos_in;
                    req_d.ctype = click_type_e'(press);
                    state_d     = ST_RANGE;
                end
            end
            ST_RANGE: begin
                if (outside) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = req_q.x - X_OFS;
                    col_d   = '0;
                    state_d = ST_COL;
                end
            end
            // One subtraction per cycle; the extra cycle that finds rem < CELL
            // also seeds the row division.
            ST_COL: begin
                if (rem_q >= CELL) begin
                    rem_d = rem_q - CELL;
                    col_d = col_q + 1'b1;
                end else begin
                    rem_d   = req_q.y - Y_OFS;
                    row_d   = '0;
                    state_d = ST_ROW;
                end
            end
            ST_ROW: begin
                if (rem_q >= CELL) begin
                    rem_d = rem_q - CELL;
                    row_d = row_q + 1'b1;
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (click_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rem_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rem_q   <= rem_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        click_valid = (state_q == ST_VALID);
        click_col   = click_valid ? col_q : '0;
        click_row   = click_valid ? row_q : '0;
        click_type  = click_valid ? req_q.ctype : CLICK_NONE;
    end

`ifdef CLICK_STATS_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (busy && (|press) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_mouse_click_decoder.sv
// Randomized and directed bench for mouse_click_decoder against a
// cell-arithmetic reference model.
module tb_mouse_click_decoder;

    localparam int BX = 240, BY = 100, CS = 40, GS = 16;

    logic        clk, rst_n;
    logic [11:0] xpos_in, ypos_in;
    logic        left_in, right_in;
    logic        click_valid, click_ready;
    logic [4:0]  click_col, click_row;
    logic [1:0]  click_type;
    logic        busy;
`ifdef CLICK_STATS_EN
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int failures = 0;

    mouse_click_decoder #(
        .BOARD_XPOS(BX), .BOARD_YPOS(BY), .CELL_SIZE(CS), .GRID_SIZE(GS)
    ) dut (
`ifdef CLICK_STATS_EN
        .drop_cnt    (drop_cnt),
`endif
        .clk         (clk),
        .rst_n       (rst_n),
        .xpos_in     (xpos_in),
        .ypos_in     (ypos_in),
        .left_in     (left_in),
        .right_in    (right_in),
        .click_valid (click_valid),
        .click_ready (click_ready),
        .click_col   (click_col),
        .click_row   (click_row),
        .click_type  (click_type),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: a click lands in cell floor((p-origin)/CS) if within the board.
    function automatic bit in_board(input int x, input int y);
        return x >= BX && x < BX + GS*CS && y >= BY && y < BY + GS*CS;
    endfunction

    // Releases both buttons for a cycle, then presses; returns after the capture edge.
    task automatic press(input int x, input int y, input bit l, input bit r);
        @(negedge clk);
        left_in = 1'b0; right_in = 1'b0;
        @(negedge clk);
        xpos_in = 12'(x); ypos_in = 12'(y);
        left_in = l; right_in = r;
        @(posedge clk); #1;
    endtask

    // Full transaction: press, measure latency, hold ready low, handshake.
    task automatic click(input string tag, input int x, input int y, input bit l, input bit r,
                         input int hold);
        int n, ecol, erow, elat;
        logic [1:0] etype;
        etype = {r, l};
        press(x, y, l, r);
        left_in = 1'b0; right_in = 1'b0;
        if (!in_board(x, y)) begin
            chk({tag, "_out_busy"}, busy, 1);
            @(posedge clk); #1;
            chk({tag, "_out_idle"}, {busy, click_valid}, 0);
            return;
        end
        ecol = (x - BX) / CS;
        erow = (y - BY) / CS;
        elat = ecol + erow + 3;
        n = 0;
        while (!click_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_payload"}, {click_col, click_row, click_type},
            {5'(ecol), 5'(erow), etype});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {click_valid, click_col, click_row, click_type},
                {1'b1, 5'(ecol), 5'(erow), etype});
        end
        click_ready = 1'b1;
        @(posedge clk); #1;
        click_ready = 1'b0;
        chk({tag, "_done"}, {busy, click_valid, click_col, click_row, click_type}, 0);
    endtask

    initial begin
        int bsum, x, y, t;
        logic [7:0] drop0;
        rst_n = 1'b0; xpos_in = '0; ypos_in = '0;
        left_in = 1'b0; right_in = 1'b0; click_ready = 1'b0;
        drop0 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {busy, click_valid, click_col, click_row, click_type}, 0);
`ifdef CLICK_STATS_EN
        chk("reset_drop", drop_cnt, 0);
`endif
        @(negedge clk); rst_n = 1'b1;

        click("corner_tl", 240, 100, 1, 0, 0);
        click("corner_br", 879, 739, 0, 1, 2);
        click("chord", 300, 150, 1, 1, 1);

`ifdef CLICK_STATS_EN
        drop0 = drop_cnt;
`endif
        bsum = 0;
        press(880, 300, 1, 0);
        left_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bsum += int'(busy);
            chk("right_edge_novalid", click_valid, 0);
            @(posedge clk); #1;
        end
        press(239, 300, 1, 0);
        left_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bsum += int'(busy);
            chk("left_edge_novalid", click_valid, 0);
            @(posedge clk); #1;
        end
        chk("outside_busy_cycles", bsum, 2);
`ifdef CLICK_STATS_EN
        chk("outside_drop", drop_cnt, drop0);
`endif

        for (int k = 0; k < 40; k++) begin
            x = $urandom_range(220, 900);
            y = $urandom_range(80, 760);
            t = $urandom_range(1, 3);
            click("rand", x, y, t[0], t[1], $urandom_range(0, 3));
        end

        // Stalled consumer plus a re-press during VALID that must be dropped.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        press(380, 220, 1, 0);
        left_in = 1'b0;
        while (!click_valid && bsum < 500) begin
            @(posedge clk); #1; bsum++;
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) left_in = 1'b1;
            chk("stall_payload", {click_valid, click_col, click_row, click_type},
                {1'b1, 5'd3, 5'd3, 2'b01});
            @(posedge clk); #1;
        end
`ifdef CLICK_STATS_EN
        chk("stall_drop", drop_cnt, 1);
`endif
        click_ready = 1'b1;
        @(posedge clk); #1;
        click_ready = 1'b0;
        t = 0;
        for (int i = 0; i < 40; i++) begin
            t += int'(click_valid) + int'(busy);
            @(posedge clk); #1;
        end
        chk("no_late_event", t, 0);
        left_in = 1'b0;

        // Asynchronous reset in the middle of the column division.
        press(879, 739, 1, 0);
        left_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {busy, click_valid, click_col, click_row, click_type}, 0);
`ifdef CLICK_STATS_EN
        chk("async_reset_drop", drop_cnt, 0);
`endif
        @(negedge clk); rst_n = 1'b1;
        click("after_reset", 300, 150, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_click_decoder.md
MOUSE_CLICK_DECODER -- requirements
Module: mouse_click_decoder

Interface
REQ-001 SHALL have parameter BOARD_XPOS, default 240; pixel x of the board's left edge.
REQ-002 SHALL have parameter BOARD_YPOS, default 100; pixel y of the board's top edge.
REQ-003 SHALL have parameter CELL_SIZE, default 40; cell edge length in pixels (1..255).
REQ-004 SHALL have parameter GRID_SIZE, default 16; cells per row and column (1..31).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, the slow/pixel domain.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports xpos_in and ypos_in, input, 12 bits each: mouse position, already synchronous to clk.
REQ-008 SHALL have ports left_in and right_in, input, 1 bit each: button levels, synchronous to clk.
REQ-009 SHALL have port click_valid, output, 1 bit: click event available.
REQ-010 SHALL have port click_ready, input, 1 bit: consumer accepts the event.
REQ-011 SHALL have ports click_col and click_row, output, 5 bits each: cell indices of the event.
REQ-012 SHALL have port click_type, output, 2 bits: 01 left/reveal, 10 right/flag, 11 both/chord.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL register left_in and right_in every cycle; a press is input high while its registered copy is low.
REQ-015 SHALL update the registered button copies in every state, so presses ignored while busy never fire later.
REQ-016 SHALL use FSM states IDLE, RANGE, COL, ROW and VALID.
REQ-017 SHALL, in IDLE on a press, capture xpos_in, ypos_in and the type, then go to RANGE.
REQ-018 SHALL set type 11 when left and right presses occur in the same cycle.
REQ-019 SHALL, in RANGE, treat a point as outside when x < BOARD_XPOS, x >= BOARD_XPOS+GRID_SIZE*CELL_SIZE, or the same tests on y. Bounds SHALL be computed at 13 bits.
REQ-020 SHALL go from RANGE to IDLE when outside, with no event and no drop count.
REQ-021 SHALL go from RANGE to COL when inside, loading rem = x-BOARD_XPOS and col = 0.
REQ-022 SHALL, in COL, do rem -= CELL_SIZE and col++ while rem >= CELL_SIZE; otherwise load rem = y-BOARD_YPOS and row = 0, then go to ROW.
REQ-023 SHALL run ROW the same way as COL, ending in VALID.
REQ-024 SHALL hold click_valid high in VALID, with click_col, click_row and click_type stable until click_valid && click_ready, then go to IDLE.
REQ-025 SHALL give a latency from the capture edge to click_valid of exactly col+row+3 cycles.
REQ-026 SHALL drive click_valid, click_col, click_row and click_type to 0 outside VALID.
REQ-027 SHALL treat a press in IDLE on the same edge that leaves VALID as not captured (dropped).

Reset
REQ-028 SHALL, while rst_n is low, immediately force the FSM to IDLE and every output and internal register to 0, including mid-division.
REQ-029 SHALL process the first press after reset release normally.

Configuration
REQ-030 SHALL, with CLICK_STATS_EN defined, add output drop_cnt (8 bits, reset 0). It SHALL increment, saturating at 255, on each press detected outside IDLE.
REQ-031 SHALL, without CLICK_STATS_EN, omit the drop_cnt port and its logic entirely; behaviour is otherwise identical.

Structure
REQ-032 SHALL take the click_type encoding (enum), the FSM state enum and the 5-bit cell index width from shared package mouse_pkg.
REQ-033 SHALL implement press detection in sub-module button_edge_det (one instance per button); the division SHALL remain inline.

Verification (default parameters: board x 240..879, y 100..739)
REQ-034 SHALL cover: left press at (240,100) -> click_valid 3 cycles later, col=0, row=0, type=01.
REQ-035 SHALL cover: right press at (879,739) -> click_valid 33 cycles later, col=15, row=15, type=10.
REQ-036 SHALL cover: left presses at (880,300) and (239,300) -> no click_valid, busy high for 2 cycles, drop_cnt unchanged.
REQ-037 SHALL cover: left and right rising together at (300,150) -> col=1, row=1, type=11, latency 5.
REQ-038 SHALL cover: click_ready low for 10 cycles, then a left re-press during VALID -> payload stable throughout, drop_cnt=1 (macro on), and no event after the handshake.
REQ-039 SHALL cover: rst_n low during COL -> all outputs 0 at once; the next press at (300,150) yields col=1, row=1.
